ysyx_24070016_ifu: RTL
======================

Name: ysyx_24070016_ifu

Overview:
- Instruction fetch unit: the producer side of the 32-bit instruction word consumed by the decode stage.
- Owns the PC and issues single-outstanding read requests to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Presents each fetched word to decode over a valid/ready handshake together with its PC and a fault flag.
- Handles redirects from execute and a halt (ebreak) from decode.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- XLEN, 32, PC and instruction width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address, word aligned.
- imem_rsp_valid  in  1  read data valid, single-cycle pulse.
- imem_rsp_data  in  32  read data.
- imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.
- inst_fault  out  1  fetch fault for inst.
- redirect_valid  in  1  control-flow redirect.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and treated as 00.
- halt  in  1  stop fetching (ebreak retired); sticky until reset.

Behaviour:
- All state and outputs are registered.
- Reset values: pc=RESET_PC, state=IDLE, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, kill=0.
- States: IDLE, REQ, WAIT, HOLD, STALL, HALT.
- IDLE: next cycle goes to REQ with imem_req_valid=1 and imem_req_addr=pc.
- REQ:
  - Holds valid and addr stable until imem_req_ready; addr never changes while valid is high and unaccepted.
  - On handshake: valid->0, go to WAIT.
- WAIT:
  - On imem_rsp_valid with kill=0: register inst=data, inst_pc=pc, inst_fault=err; inst_valid=1; go to HOLD.
  - On imem_rsp_valid with kill=1: discard the response, clear kill, go to REQ with addr=pc (already the redirect target).
- HOLD:
  - inst, inst_pc and inst_fault are held stable while inst_valid=1 and inst_ready=0.
  - On handshake with fault=0: pc=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0); inst_valid->0; go to REQ.
  - On handshake with fault=1: inst_valid->0; go to STALL (no sequential fetch after a fault).
- STALL: waits for redirect_valid, then goes to REQ at the redirect PC.
- Redirect, valid in any state except HALT:
  - pc={redirect_pc[31:2],2'b00} in all cases.
  - REQ with request not yet accepted: request stays up at the old addr (stability rule); set kill.
  - REQ with handshake in the same cycle: go to WAIT with kill=1.
  - WAIT: kill=1; the in-flight response is discarded.
  - HOLD: inst_valid->0 next cycle even if inst_ready is high the same cycle; no pc+4; go to REQ.
  - IDLE/STALL: go to REQ.
  - Redirect always beats the sequential pc+4.
- Halt:
  - If no response is outstanding (IDLE/REQ-unaccepted/HOLD/STALL): go to HALT next cycle; imem_req_valid->0, inst_valid->0.
  - WAIT or REQ-accepting-this-cycle: wait for the response, drop it, then go to HALT.
  - HALT is exited only by reset. Halt has priority over redirect.
- Protocol:
  - At most one outstanding request.
  - imem_rsp_valid outside WAIT is ignored; the bench flags it as an error.
- Latency:
  - Request handshake at cycle t, response at t+k (k>=1), inst_valid at t+k+1.
  - After an inst handshake, the next request is raised on the following cycle.
- Reset asserted mid-transaction: asynchronous return to reset values. A stale response arriving after reset deassert is ignored because state is IDLE.

Decomposition:
- Package ysyx_24070016_pkg holds:
  - state enum (IDLE, REQ, WAIT, HOLD, STALL, HALT);
  - RESET_PC default;
  - INST_NOP = 32'h0000_0013;
  - INST_W = 32.
- No sub-module: FSM plus PC register fits in one module.

Test Plan:
- Reset then always-ready memory with 1-cycle latency returning 32'h0010_0093 -> first request addr 32'h8000_0000, inst_valid with inst_pc 32'h8000_0000, then next request at 32'h8000_0004.
- inst_ready held low 5 cycles in HOLD -> inst/inst_pc stable, no new imem request. Ready rises -> pc advances by 4 exactly once.
- redirect_valid to 32'h8000_0103 while in WAIT -> in-flight response dropped, never shown on inst; next request addr 32'h8000_0100.
- imem_rsp_err=1 at 32'h8000_0008 -> inst_fault=1, inst_pc 32'h8000_0008; after handshake no requests until redirect to 32'h8000_0000, which resumes fetch there.
- halt during WAIT -> response dropped, imem_req_valid stays 0 for 20 cycles, redirect ignored. rst pulse -> fetch restarts at RESET_PC.
- pc 32'hFFFF_FFFC via redirect, accept the instruction -> next request addr 32'h0000_0000.

Source files
------------

// File: rtl/ysyx_24070016_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_24070016_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        STALL = 3'd4,
        HALT  = 3'd5
    } ifu_state_t;

endpackage

// File: rtl/ysyx_24070016_ifu.sv
// Instruction fetch: owns the PC, keeps one imem read in flight, hands words to decode.
// Latency: req handshake at t, rsp at t+k, inst_valid at t+k+1; decode backpressure holds the word.
module ysyx_24070016_ifu
    import ysyx_24070016_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = INST_W
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt
);

    ifu_state_t      state, n_state;
    logic [XLEN-1:0] pc, n_pc;
    logic            kill, n_kill;
    logic            halt_q;
    logic            n_req_valid, n_inst_valid, n_inst_fault;
    logic [XLEN-1:0] n_req_addr, n_inst, n_inst_pc;
    logic            halting;
    logic [XLEN-1:0] redir;

    // halt is latched so the unit stays halted even if decode drops the pulse
    assign halting = halt | halt_q;
    assign redir   = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        n_state      = state;
        n_pc         = pc;
        n_kill       = kill;
        n_req_valid  = imem_req_valid;
        n_req_addr   = imem_req_addr;
        n_inst_valid = inst_valid;
        n_inst       = inst;
        n_inst_pc    = inst_pc;
        n_inst_fault = inst_fault;
        case (state)
            IDLE: begin
                if (halting) begin
                    n_state = HALT;
                end else begin
                    n_state     = REQ;
                    n_req_valid = 1'b1;
                    n_req_addr  = redirect_valid ? redir : pc;
                    n_pc        = redirect_valid ? redir : pc;
                end
            end
            REQ: begin
                if (imem_req_ready) begin
                    n_req_valid = 1'b0;
                    n_state     = WAIT;
                    if (!halting && redirect_valid) begin
                        n_pc   = redir;
                        n_kill = 1'b1;
                    end
                end else if (halting) begin
                    n_req_valid = 1'b0;
                    n_state     = HALT;
                end else if (redirect_valid) begin
                    // address must stay put until accepted; the response gets dropped
                    n_pc   = redir;
                    n_kill = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    n_kill = 1'b0;
                    if (halting) begin
                        n_state = HALT;
                    end else if (kill || redirect_valid) begin
                        n_state     = REQ;
                        n_req_valid = 1'b1;
                        n_req_addr  = redirect_valid ? redir : pc;
                        n_pc        = redirect_valid ? redir : pc;
                    end else begin
                        n_state      = HOLD;
                        n_inst_valid = 1'b1;
                        n_inst       = imem_rsp_data;
                        n_inst_pc    = pc;
                        n_inst_fault = imem_rsp_err;
                    end
                end else if (!halting && redirect_valid) begin
                    n_pc   = redir;
                    n_kill = 1'b1;
                end
            end
            HOLD: begin
                if (halting) begin
                    n_inst_valid = 1'b0;
                    n_state      = HALT;
                end else if (redirect_valid) begin
                    n_inst_valid = 1'b0;
                    n_pc         = redir;
                    n_req_valid  = 1'b1;
                    n_req_addr   = redir;
                    n_state      = REQ;
                end else if (inst_ready) begin
                    n_inst_valid = 1'b0;
                    if (inst_fault) begin
                        n_state = STALL;
                    end else begin
                        n_pc        = pc + 32'd4;
                        n_req_valid = 1'b1;
                        n_req_addr  = pc + 32'd4;
                        n_state     = REQ;
                    end
                end
            end
            STALL: begin
                if (halting) begin
                    n_state = HALT;
                end else if (redirect_valid) begin
                    n_pc        = redir;
                    n_req_valid = 1'b1;
                    n_req_addr  = redir;
                    n_state     = REQ;
                end
            end
            HALT: begin
                n_req_valid  = 1'b0;
                n_inst_valid = 1'b0;
            end
            default: begin
                n_state      = IDLE;
                n_req_valid  = 1'b0;
                n_inst_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            halt_q         <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
            inst_fault     <= 1'b0;
        end else begin
            state          <= n_state;
            pc             <= n_pc;
            kill           <= n_kill;
            halt_q         <= halt_q | halt;
            imem_req_valid <= n_req_valid;
            imem_req_addr  <= n_req_addr;
            inst_valid     <= n_inst_valid;
            inst           <= n_inst;
            inst_pc        <= n_inst_pc;
            inst_fault     <= n_inst_fault;
        end
    end

endmodule
